carregador_matriz: RTL and testbench
====================================

CARREGADOR_MATRIZ -- requirements
Module: carregador_matriz

Interface
REQ-001 The block SHALL have no parameters; matrix size is fixed at 5x5 and element width at 8 bits, signed two's complement.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 flush  input  1  synchronous abort of a partial load; same effect as reset on load state only.
REQ-005 in_data  input  8  signed byte stream: elements 0..24 in order, then the scalar.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 matriz_A  output  200  assembled matrix; element i at bits [8i+7:8i], row-major (i = 5*row + col).
REQ-009 num_inteiro  output  8  assembled signed scalar.
REQ-010 out_valid  output  1  matriz_A and num_inteiro are complete and stable.
REQ-011 out_ready  input  1  downstream consumes the held matrix/scalar pair.
REQ-012 contador  output  5  number of bytes accepted in the current load, 0..25.

Function
REQ-013 A byte transfer SHALL occur exactly in cycles where in_valid and in_ready are both 1; no other cycle changes matriz_A or num_inteiro.
REQ-014 FSM states SHALL be LOAD, SCALAR, HOLD; encoding is free.
REQ-015 LOAD: in_ready=1, out_valid=0. Transfer k (contador=k, 0..24) writes in_data to element k and increments contador. The transfer with k=24 moves to SCALAR.
REQ-016 SCALAR: in_ready=1, out_valid=0. A transfer writes num_inteiro, sets contador=25, and moves to HOLD.
REQ-017 HOLD: in_ready=0, out_valid=1. matriz_A and num_inteiro are frozen.
REQ-018 In HOLD, out_ready=1 SHALL move to LOAD the next cycle with contador=0 and out_valid=0.
REQ-019 matriz_A and num_inteiro SHALL retain their values after leaving HOLD until overwritten byte by byte. Elements not yet rewritten keep their old values.
REQ-020 Latency: out_valid SHALL rise on the cycle after the 26th transfer, and outputs are registered. Minimum load time is 26 cycles. A back-to-back load SHALL be possible with one bubble cycle (the HOLD exit cycle).
REQ-021 in_valid=0 in LOAD or SCALAR SHALL stall with all state held, for any duration.
REQ-022 flush=1 in any state SHALL force LOAD with contador=0 and out_valid=0 on the next cycle. Any transfer in that same cycle is discarded (in_ready is 1 but the write is suppressed). Matrix contents are otherwise retained.
REQ-023 If flush and out_ready are both 1 in HOLD, flush governs; the result is identical to REQ-018.
REQ-024 in_data SHALL be stored bit-exact with no sign extension, saturation or arithmetic; the 200-bit bus is a pure concatenation.
REQ-025 contador SHALL never exceed 25 and never wrap. Further in_valid while in HOLD is ignored (in_ready=0).
REQ-026 in_ready SHALL depend only on registered state, with no combinational path from in_valid or out_ready.

Reset
REQ-027 On reset=1 the following SHALL hold on the next edge:
- State = LOAD, contador=0.
- matriz_A=200'h0, num_inteiro=8'h00.
- out_valid=0, in_ready=1.
REQ-028 reset SHALL take priority over flush and all handshakes, including reset asserted mid-load or in HOLD.
REQ-029 Outputs SHALL be defined (not X) from the first edge with reset=1.

Verification
REQ-030 Full load: stream bytes 1..25, then 8'hFE with in_valid held high -> out_valid rises on the cycle after the 26th transfer. Required values: matriz_A[7:0]=1, matriz_A[199:192]=25, num_inteiro=8'hFE (-2), contador=25, in_ready=0.
REQ-031 Stall: same stream with in_valid low for 3 cycles after byte 10 -> contador holds at 10 during the gap, and the final result is identical to REQ-030.
REQ-032 Hold/handshake: in HOLD, hold out_ready=0 for 5 cycles and then pulse it -> outputs are stable for all 5 cycles; on the next cycle out_valid=0, contador=0, in_ready=1, and matriz_A still equals the prior value.
REQ-033 Flush mid-load: after 12 bytes of 8'h80, assert flush while in_valid=1 with 8'h7F -> the 8'h7F is discarded and contador=0. A fresh load of 26 bytes of 8'h7F then gives matriz_A={25{8'h7F}}, num_inteiro=8'h7F.
REQ-034 Reset priority: assert reset together with flush and out_ready while in HOLD -> next cycle matriz_A=0, num_inteiro=0, out_valid=0, contador=0.
REQ-035 Back-to-back: two consecutive loads with out_ready tied to 1 -> exactly 27 cycles between the rising edges of out_valid when in_valid is continuous.

Source files
------------

// File: rtl/carregador_matriz_if.sv
// Byte-stream input and matrix/scalar output handshakes for carregador_matriz.
// The master side is the producer/consumer pair outside the loader.
interface carregador_matriz_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matriz_A;
    logic [7:0]   num_inteiro;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  matriz_A,
        input  num_inteiro,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output matriz_A,
        output num_inteiro,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/carregador_matriz.sv
// Assembles a 5x5 signed-byte matrix followed by one signed scalar from a
// valid/ready byte stream, then holds the pair until downstream accepts it.
module carregador_matriz (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    carregador_matriz_if.slave         bus,
    output logic [4:0]                 contador
);
    localparam int N_ELEM = 25;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SCALAR = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  contador_q, contador_d;
    logic [7:0]  elem_q [N_ELEM];
    logic [7:0]  scalar_q;

    logic        in_ready_int;
    logic        xfer;
    logic        write_elem;
    logic        write_scalar;
    wire  [199:0] matriz_flat;

    // Readiness decodes only the state register, so there is no path from
    // in_valid or out_ready into in_ready.
    assign in_ready_int = (state_q != HOLD);
    assign xfer         = bus.in_valid && in_ready_int && !flush;
    assign write_elem   = xfer && (state_q == LOAD);
    assign write_scalar = xfer && (state_q == SCALAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            contador_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            contador_q <= contador_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        contador_d = contador_q;
        if (flush) begin
            state_d    = LOAD;
            contador_d = 5'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        contador_d = contador_q + 5'd1;
                        if (contador_q == 5'd24) begin
                            state_d = SCALAR;
                        end
                    end
                end
                SCALAR: begin
                    if (bus.in_valid) begin
                        contador_d = 5'd25;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        contador_d = 5'd0;
                        state_d    = LOAD;
                    end
                end
                default: begin
                    state_d    = LOAD;
                    contador_d = 5'd0;
                end
            endcase
        end
    end

    // Element storage keeps old contents between loads; only the slot
    // addressed by contador is overwritten on a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ELEM; i++) begin
                elem_q[i] <= 8'h00;
            end
            scalar_q <= 8'h00;
        end else begin
            if (write_elem && (contador_q < 5'd25)) begin
                elem_q[contador_q] <= bus.in_data;
            end
            if (write_scalar) begin
                scalar_q <= bus.in_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_pack
            assign matriz_flat[8*gi +: 8] = elem_q[gi];
        end
    endgenerate

    assign bus.matriz_A    = matriz_flat;
    assign bus.num_inteiro = scalar_q;
    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = (state_q == HOLD);
    assign contador        = contador_q;
endmodule

// File: tb/tb_carregador_matriz.sv
// Directed bench for carregador_matriz: full load, stall, hold handshake,
// flush mid-load, reset priority and back-to-back throughput.
module tb_carregador_matriz;
    logic        clk;
    logic        reset;
    logic        flush;
    logic [4:0]  contador;

    int checks;
    int failures;

    logic [199:0] exp_a;
    logic [199:0] held_a;

    carregador_matriz_if bus ();

    carregador_matriz dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus.slave),
        .contador (contador)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [199:0] got,
                             input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        step();
    endtask

    // Matrix whose element i holds i+1.
    function automatic logic [199:0] ramp_matrix();
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 25; i++) m[8*i +: 8] = 8'(i + 1);
        return m;
    endfunction

    task automatic leave_hold();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  rise0;
        int  rise1;
        int  nrise;
        logic prev_ov;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        reset = 1'b0;
        check_val("rst_matriz", bus.matriz_A, 200'h0);
        check_val("rst_num", {192'h0, bus.num_inteiro}, 200'h0);
        check_val("rst_out_valid", {199'h0, bus.out_valid}, 200'h0);
        check_val("rst_in_ready", {199'h0, bus.in_ready}, 200'h1);
        check_val("rst_contador", {195'h0, contador}, 200'h0);

        // Full load 1..25 then FE, in_valid continuous
        exp_a = ramp_matrix();
        for (int i = 0; i < 25; i++) send_byte(8'(i + 1));
        check_val("full_pre_ov", {199'h0, bus.out_valid}, 200'h0);
        check_val("full_pre_cnt", {195'h0, contador}, 200'd25);
        send_byte(8'hFE);
        bus.in_data = 8'h55;  // keep in_valid high in HOLD: must be ignored
        check_val("full_ov", {199'h0, bus.out_valid}, 200'h1);
        check_val("full_matriz", bus.matriz_A, exp_a);
        check_val("full_a0", {192'h0, bus.matriz_A[7:0]}, 200'd1);
        check_val("full_a24", {192'h0, bus.matriz_A[199:192]}, 200'd25);
        check_val("full_num", {192'h0, bus.num_inteiro}, 200'hFE);
        check_val("full_cnt", {195'h0, contador}, 200'd25);
        check_val("full_in_ready", {199'h0, bus.in_ready}, 200'h0);

        // Hold with out_ready low for 5 cycles, then pulse
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("hold%0d_ov", i), {199'h0, bus.out_valid}, 200'h1);
            check_val($sformatf("hold%0d_matriz", i), bus.matriz_A, exp_a);
            check_val($sformatf("hold%0d_num", i), {192'h0, bus.num_inteiro}, 200'hFE);
            check_val($sformatf("hold%0d_cnt", i), {195'h0, contador}, 200'd25);
        end
        leave_hold();
        check_val("exit_ov", {199'h0, bus.out_valid}, 200'h0);
        check_val("exit_cnt", {195'h0, contador}, 200'h0);
        check_val("exit_in_ready", {199'h0, bus.in_ready}, 200'h1);
        check_val("exit_matriz", bus.matriz_A, exp_a);
        check_val("exit_num", {192'h0, bus.num_inteiro}, 200'hFE);

        // Stall: 3 idle cycles after byte 10
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("stall%0d_cnt", i), {195'h0, contador}, 200'd10);
        end
        for (int i = 10; i < 25; i++) send_byte(8'(i + 1));
        send_byte(8'hFE);
        bus.in_valid = 1'b0;
        check_val("stall_ov", {199'h0, bus.out_valid}, 200'h1);
        check_val("stall_matriz", bus.matriz_A, exp_a);
        check_val("stall_num", {192'h0, bus.num_inteiro}, 200'hFE);
        check_val("stall_cnt", {195'h0, contador}, 200'd25);
        leave_hold();

        // Flush mid-load: 12 bytes of 80, then flush with a 7F offered
        for (int i = 0; i < 12; i++) send_byte(8'h80);
        bus.in_data = 8'h7F;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) exp_a[8*i +: 8] = 8'h80;
        check_val("flush_cnt", {195'h0, contador}, 200'h0);
        check_val("flush_ov", {199'h0, bus.out_valid}, 200'h0);
        check_val("flush_matriz", bus.matriz_A, exp_a);
        check_val("flush_num", {192'h0, bus.num_inteiro}, 200'hFE);
        for (int i = 0; i < 26; i++) send_byte(8'h7F);
        bus.in_valid = 1'b0;
        check_val("fresh_ov", {199'h0, bus.out_valid}, 200'h1);
        check_val("fresh_matriz", bus.matriz_A, {25{8'h7F}});
        check_val("fresh_num", {192'h0, bus.num_inteiro}, 200'h7F);

        // Back-to-back with out_ready tied high and continuous in_valid
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev_ov = bus.out_valid;
        rise0 = 0;
        rise1 = 0;
        nrise = 0;
        for (cyc = 1; cyc <= 200 && nrise < 2; cyc++) begin
            bus.in_data = 8'(cyc);
            step();
            if (bus.out_valid && !prev_ov) begin
                if (nrise == 0) rise0 = cyc;
                else rise1 = cyc;
                nrise++;
            end
            prev_ov = bus.out_valid;
        end
        check_val("b2b_rises", 200'(nrise), 200'd2);
        check_val("b2b_period", 200'(rise1 - rise0), 200'd27);

        // Reset priority in HOLD
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if (!bus.out_valid) begin
            for (int i = 0; i < 26; i++) send_byte(8'h33);
            bus.in_valid = 1'b0;
        end
        check_val("rp_pre_ov", {199'h0, bus.out_valid}, 200'h1);
        held_a = bus.matriz_A;
        check_val("rp_pre_nonzero", {199'h0, (held_a != 200'h0)}, 200'h1);
        reset = 1'b1;
        flush = 1'b1;
        bus.out_ready = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        check_val("rp_matriz", bus.matriz_A, 200'h0);
        check_val("rp_num", {192'h0, bus.num_inteiro}, 200'h0);
        check_val("rp_ov", {199'h0, bus.out_valid}, 200'h0);
        check_val("rp_cnt", {195'h0, contador}, 200'h0);
        check_val("rp_in_ready", {199'h0, bus.in_ready}, 200'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
